// File: rtl/aes128_iter_core.sv
// rtl/aes128_iter_core.sv - iterative AES-128 encryptor, one round per clock
// Optional AES_CT_GATE_EN: ciphertext port shows the result only in the done cycle.
module aes128_iter_core (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic [127:0] ciphertext
);

    // FIPS-197 S-box, entry 0 in the most significant byte
    localparam logic [2047:0] C_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t       r_fsm;
    logic [3:0]   r_round;
    logic [127:0] r_state;
    logic [127:0] r_rk;
    logic [127:0] r_ct;
    logic         r_busy;
    logic         r_done;

    logic [127:0] w_sr;
    logic [127:0] w_mc;
    logic [127:0] w_next_rk;
    logic [127:0] w_next_state;
    logic [31:0]  w_kx;
    logic [7:0]   w_rcon;

    // 2047 - 8*b is the bitwise complement of {b,000} in 11 bits
    function automatic logic [7:0] f_sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = ~{b, 3'b000};
        return C_SBOX[idx -: 8];
    endfunction

    function automatic logic [7:0] f_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] f_sub_word(input logic [31:0] w);
        return {f_sbox(w[31:24]), f_sbox(w[23:16]), f_sbox(w[15:8]), f_sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] f_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = f_xtime(a0) ^ f_xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ f_xtime(a1) ^ f_xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ f_xtime(a2) ^ f_xtime(a3) ^ a3;
        b3 = f_xtime(a0) ^ a0 ^ a1 ^ a2 ^ f_xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    function automatic logic [7:0] f_rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // SubBytes fused with ShiftRows: row r rotates left by r columns
    always_comb begin
        w_sr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr[127 - 8*(r + 4*c) -: 8] = f_sbox(r_state[127 - 8*(r + 4*((c + r) % 4)) -: 8]);
            end
        end
    end

    always_comb begin
        w_mc = '0;
        for (int c = 0; c < 4; c++) begin
            w_mc[127 - 32*c -: 32] = f_mix_col(w_sr[127 - 32*c -: 32]);
        end
    end

    assign w_rcon                = f_rcon(r_round);
    assign w_kx                  = f_sub_word({r_rk[23:0], r_rk[31:24]}) ^ {w_rcon, 24'h0};
    assign w_next_rk[127:96]     = r_rk[127:96] ^ w_kx;
    assign w_next_rk[95:64]      = r_rk[95:64]  ^ w_next_rk[127:96];
    assign w_next_rk[63:32]      = r_rk[63:32]  ^ w_next_rk[95:64];
    assign w_next_rk[31:0]       = r_rk[31:0]   ^ w_next_rk[63:32];
    assign w_next_state          = ((r_round == 4'd10) ? w_sr : w_mc) ^ w_next_rk;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fsm   <= ST_IDLE;
            r_round <= 4'd0;
            r_state <= '0;
            r_rk    <= '0;
            r_ct    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= plaintext ^ key;
                        r_rk    <= key;
                        r_round <= 4'd1;
                        r_busy  <= 1'b1;
                        r_fsm   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_state <= w_next_state;
                    r_rk    <= w_next_rk;
                    if (r_round == 4'd10) begin
                        r_ct    <= w_next_state;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_round <= 4'd0;
                        r_fsm   <= ST_IDLE;
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                default: r_fsm <= ST_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;

`ifdef AES_CT_GATE_EN
    assign ciphertext = r_done ? r_ct : 128'h0;
`else
    assign ciphertext = r_ct;
`endif

endmodule

// File: tb/tb_aes128_iter_core.sv
// tb/tb_aes128_iter_core.sv - directed FIPS-197 vector bench for aes128_iter_core
module tb_aes128_iter_core;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         busy;
    logic         done;
    logic [127:0] ciphertext;

    int checks = 0;
    int errors = 0;

    aes128_iter_core dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .plaintext  (plaintext),
        .key        (key),
        .busy       (busy),
        .done       (done),
        .ciphertext (ciphertext)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("%s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one start and returns at the negedge of the done cycle (or after the bound).
    task automatic run_op(input string tag, input logic [127:0] p, input logic [127:0] k,
                          input logic [127:0] exp);
        int cyc;
        int busy_cnt;
        @(negedge clk);
        plaintext = p;
        key       = k;
        start     = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        cyc      = 0;
        busy_cnt = 0;
        while (!done && cyc < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, cyc, 10);
        chk({tag, "_busy_cycles"}, busy_cnt, 10);
        chk({tag, "_busy_in_done"}, busy, 0);
        chk({tag, "_ct"}, ciphertext, exp);
    endtask

    initial begin
        int n;
        int done_cnt;
        int done_cyc;
        logic [127:0] cap;

        reset     = 1'b0;
        start     = 1'b0;
        plaintext = '0;
        key       = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ct", ciphertext, 0);
        reset = 1'b1;

        run_op("c1", C1_PT, C1_KEY, C1_CT);
        @(negedge clk);
        chk("c1_done_one_cycle", done, 0);
`ifdef AES_CT_GATE_EN
        chk("c1_ct_gated_after", ciphertext, 0);
`else
        chk("c1_ct_hold", ciphertext, C1_CT);
`endif

        run_op("appb", B_PT, B_KEY, B_CT);

        run_op("zero", 128'h0, 128'h0, Z_CT);
        plaintext = C1_PT;
        key       = C1_KEY;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n     = 1;
        chk("b2b_accepted_busy", busy, 1);
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_spacing", n, 11);
        chk("b2b_ct", ciphertext, C1_CT);

        @(negedge clk);
        plaintext = B_PT;
        key       = B_KEY;
        start     = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        done_cnt = 0;
        done_cyc = -1;
        cap      = '0;
        for (int c = 0; c < 25; c++) begin
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
                cap = ciphertext;
            end
            @(negedge clk);
            if (c >= 2 && c <= 6) begin
                plaintext = 128'hdeadbeef_00000000_cafef00d_12345678;
                key       = C1_KEY ^ {4{c[31:0]}};
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        chk("intf_done_count", done_cnt, 1);
        chk("intf_done_cycle", done_cyc, 10);
        chk("intf_ct", cap, B_CT);

        @(negedge clk);
        plaintext = C1_PT;
        key       = C1_KEY;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_ct", ciphertext, 0);
        repeat (3) @(negedge clk);
        chk("abort_no_done", done, 0);
        reset = 1'b1;
        run_op("post_rst", B_PT, B_KEY, B_CT);
        @(negedge clk);
        chk("post_rst_done_low", done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
